pipe_stage_reg: RTL

Parametrised inter-stage pipeline register for the five-stage MIPS core. It replaces the per-stage F/D, D/E, E/M and M/W registers with one block. It carries instruction, PC, a packed payload of NUM_FIELDS data words, a branch-delay flag, an exception code and a valid bit. It also provides hold (stall), bubble insertion that preserves PC/BD for CP0 EPC, exception-request flush, and saturating stall/bubble performance counters.

---
 rtl/pipe_stage_reg_if.sv | 37 +++
 rtl/pipe_stage_reg.sv | 81 ++++++++
 2 files changed

// File: rtl/pipe_stage_reg_if.sv
// Inter-stage pipeline register bus: upstream control/data in, registered slot and counters out.
// master = the surrounding pipeline, slave = the pipe_stage_reg instance.
interface pipe_stage_reg_if #(
   parameter int DATA_W     = 32,
   parameter int NUM_FIELDS = 5,
   parameter int EXC_W      = 5,
   parameter int CNT_W      = 16
);
   logic                         req;
   logic                         en;
   logic                         bubble;
   logic [DATA_W-1:0]            in_instr;
   logic [DATA_W-1:0]            in_pc;
   logic                         in_bd;
   logic [EXC_W-1:0]             in_exc;
   logic [EXC_W-1:0]             stage_exc;
   logic [NUM_FIELDS*DATA_W-1:0] in_fields;

   logic [DATA_W-1:0]            out_instr;
   logic [DATA_W-1:0]            out_pc;
   logic                         out_bd;
   logic [EXC_W-1:0]             out_exc;
   logic                         out_valid;
   logic [NUM_FIELDS*DATA_W-1:0] out_fields;
   logic [CNT_W-1:0]             hold_cnt;
   logic [CNT_W-1:0]             bubble_cnt;

   modport master (
      output req, en, bubble, in_instr, in_pc, in_bd, in_exc, stage_exc, in_fields,
      input  out_instr, out_pc, out_bd, out_exc, out_valid, out_fields, hold_cnt, bubble_cnt
   );

   modport slave (
      input  req, en, bubble, in_instr, in_pc, in_bd, in_exc, stage_exc, in_fields,
      output out_instr, out_pc, out_bd, out_exc, out_valid, out_fields, hold_cnt, bubble_cnt
   );
endinterface

// File: rtl/pipe_stage_reg.sv
// Pipeline slot register with flush, bubble and hold; 1-cycle latency, all outputs flopped.
// en=0 stalls the slot in place; priority per edge is rst > req > bubble > hold > load.
module pipe_stage_reg #(
   parameter int                DATA_W            = 32,
   parameter int                NUM_FIELDS        = 5,
   parameter int                EXC_W             = 5,
   parameter int                CNT_W             = 16,
   parameter logic [DATA_W-1:0] RESET_PC          = 32'h3000,
   parameter logic [DATA_W-1:0] REQ_PC            = 32'h4180,
   parameter bit                KEEP_PC_ON_BUBBLE = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   pipe_stage_reg_if.slave  bus
);

   typedef struct packed {
      logic [DATA_W-1:0]            instr;
      logic [DATA_W-1:0]            pc;
      logic                         bd;
      logic [EXC_W-1:0]             exc;
      logic                         valid;
      logic [NUM_FIELDS*DATA_W-1:0] fields;
   } slot_t;

   slot_t            slot_q, slot_d;
   logic [CNT_W-1:0] hold_q, hold_d;
   logic [CNT_W-1:0] bub_q, bub_d;

   always_comb begin
      slot_d = slot_q;
      hold_d = hold_q;
      bub_d  = bub_q;
      if (rst) begin
         slot_d    = '0;
         slot_d.pc = RESET_PC;
         hold_d    = '0;
         bub_d     = '0;
      end else if (bus.req) begin
         slot_d    = '0;
         slot_d.pc = REQ_PC;
      end else if (bus.bubble) begin
         // The nop keeps the faulting slot's PC/BD so CP0 can still compute EPC.
         slot_d = '0;
         if (KEEP_PC_ON_BUBBLE) begin
            slot_d.pc = bus.in_pc;
            slot_d.bd = bus.in_bd;
         end else begin
            slot_d.pc = RESET_PC;
         end
         if (bub_q != '1)
            bub_d = bub_q + 1'b1;
      end else if (!bus.en) begin
         if (hold_q != '1)
            hold_d = hold_q + 1'b1;
      end else begin
         slot_d.instr  = bus.in_instr;
         slot_d.pc     = bus.in_pc;
         slot_d.bd     = bus.in_bd;
         slot_d.exc    = (bus.in_exc != '0) ? bus.in_exc : bus.stage_exc;
         slot_d.valid  = 1'b1;
         slot_d.fields = bus.in_fields;
      end
   end

   always_ff @(posedge clk) begin
      slot_q <= slot_d;
      hold_q <= hold_d;
      bub_q  <= bub_d;
   end

   assign bus.out_instr  = slot_q.instr;
   assign bus.out_pc     = slot_q.pc;
   assign bus.out_bd     = slot_q.bd;
   assign bus.out_exc    = slot_q.exc;
   assign bus.out_valid  = slot_q.valid;
   assign bus.out_fields = slot_q.fields;
   assign bus.hold_cnt   = hold_q;
   assign bus.bubble_cnt = bub_q;

endmodule
